fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL provide parameter XLEN, default 32, address/PC width in bits (instruction data is fixed at 32 bits).
REQ-002 SHALL provide parameter DEPTH, default 4, prefetch buffer entries (power of 2, >= 2); it also bounds requests in flight.
REQ-003 SHALL provide parameter RESET_PC, default 0, first fetch address after reset (word aligned).
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-006 imem_req_valid  output  1  fetch request valid.
REQ-007 imem_req_ready  input  1  memory accepts request.
REQ-008 imem_req_addr  output  XLEN  fetch address.
REQ-009 imem_rsp_valid  input  1  instruction word returned, in request order, 1 word per cycle max.
REQ-010 imem_rsp_data  input  32  returned instruction word.
REQ-011 redirect_valid  input  1  branch/jump/exception redirect, single-cycle pulse.
REQ-012 redirect_pc  input  XLEN  redirect target.
REQ-013 instr_valid  output  1  buffer head holds a valid instruction.
REQ-014 instr_ready  input  1  decode consumes head.
REQ-015 instr_data  output  32  head instruction word.
REQ-016 instr_pc  output  XLEN  PC of head instruction.

Function
REQ-017 Request fire = imem_req_valid & imem_req_ready; response = imem_rsp_valid; pop = instr_valid & instr_ready.
REQ-018 SHALL keep fetch_pc; on request fire, fetch_pc += 4 (modulo 2^XLEN, wrap to 0 without error).
REQ-019 imem_req_addr SHALL equal fetch_pc, with bits [1:0] always 0.
REQ-020 SHALL keep counters live (in-flight requests to keep), drop (in-flight requests to discard) and count (buffer occupancy), each 0..DEPTH.
REQ-021 imem_req_valid SHALL be 1 iff live + drop + count < DEPTH and redirect_valid = 0; imem_req_addr SHALL hold stable while imem_req_valid = 1 and imem_req_ready = 0.
REQ-022 Response with drop > 0: discarded, drop -= 1, buffer and rsp_pc unchanged.
REQ-023 Response with drop = 0 and live > 0: written to buffer tail with PC = rsp_pc; rsp_pc += 4; live -= 1.
REQ-024 Response with live = 0 and drop = 0: ignored, no state change.
REQ-025 Buffer SHALL be a circular FIFO, head/tail pointers wrap modulo DEPTH; write and pop in the same cycle SHALL both take effect, including when full or when count = 1.
REQ-026 instr_valid = (count > 0); instr_data/instr_pc = head entry; buffer is registered, minimum latency response -> instr_valid is 1 cycle.
REQ-027 Overflow impossible by REQ-021 credit rule; pop with count = 0 SHALL have no effect.
REQ-028 Redirect cycle: fetch_pc <= redirect_pc with [1:0] cleared; rsp_pc <= same; buffer emptied (count <= 0, pointers reset); live <= 0.
REQ-029 Redirect cycle: drop <= drop + live + (request fire this cycle) - (response this cycle); a response in the redirect cycle SHALL be discarded regardless of drop.
REQ-030 A pop in the redirect cycle SHALL count as consumed; no instruction fetched before the redirect SHALL appear on instr_* afterwards.
REQ-031 First request after redirect SHALL be presented the cycle following the redirect, address = redirect target.
REQ-032 Back-to-back redirects: the last one wins; drop accumulates per REQ-029.
REQ-033 Steady state with zero-wait memory and instr_ready = 1 SHALL sustain 1 instruction per cycle.

Reset
REQ-034 While reset = 0: imem_req_valid = 0, instr_valid = 0, fetch_pc = rsp_pc = RESET_PC, live = drop = count = 0, pointers 0; outputs take these values asynchronously.
REQ-035 First cycle after reset deasserts: imem_req_valid = 1, imem_req_addr = RESET_PC.
REQ-036 Reset asserted mid-operation SHALL abandon all in-flight requests; responses arriving after reset release with live = drop = 0 are ignored per REQ-024.

Verification
REQ-037 Streaming: memory always ready, 1-cycle response, instr_ready = 1 -> instr_pc sequence 0x0,0x4,0x8,... one per cycle after 2-cycle fill.
REQ-038 Back-pressure: instr_ready = 0 -> exactly DEPTH (4) requests issued, imem_req_valid = 0 thereafter; single pop -> one new request next cycle.
REQ-039 Redirect with 3 in flight, redirect_pc = 0x103 -> next request addr 0x100, 3 stale responses dropped, first instr_pc = 0x100.
REQ-040 Redirect coincident with request fire and response -> that response dropped, fired request also dropped, no stale PC reaches instr_*.
REQ-041 Wrap: RESET_PC = 0xFFFFFFF8 -> requests 0xFFFFFFF8, 0xFFFFFFFC, 0x0; FIFO pointers wrap over 3*DEPTH instructions without loss.
REQ-042 Reset pulsed with 2 requests in flight and 2 buffered -> instr_valid = 0 immediately, first post-reset request addr RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: sequential instruction fetch with credit-limited prefetch FIFO and redirect flushing
module fetch_unit #(
  parameter int XLEN = 32,
  parameter int DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [31:0]     instr_data,
  output logic [XLEN-1:0] instr_pc
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [XLEN-1:0] START_PC = RESET_PC & ~XLEN'(3);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d, rsp_pc_q, rsp_pc_d, target_pc;
  logic [CW-1:0]   live_q, live_d, drop_q, drop_d, count_q, count_d;
  logic [PW-1:0]   head_q, head_d, tail_q, tail_d;
  logic [31:0]     data_q [DEPTH];
  logic [XLEN-1:0] pc_q [DEPTH];
  logic [CW+1:0]   credit;
  logic [CW:0]     drop_sum;
  logic            fire, pop, accept, discard, rsp_owed;

  // handshakes and response classification; a response during a redirect is never written
  always_comb begin
    credit         = {2'b00, live_q} + {2'b00, drop_q} + {2'b00, count_q};
    imem_req_valid = reset & ~redirect_valid & (credit < (CW + 2)'(DEPTH));
    imem_req_addr  = fetch_pc_q;
    fire           = imem_req_valid & imem_req_ready;
    instr_valid    = count_q != '0;
    instr_data     = data_q[head_q];
    instr_pc       = pc_q[head_q];
    pop            = instr_valid & instr_ready;
    rsp_owed       = (live_q != '0) | (drop_q != '0);
    discard        = imem_rsp_valid & (drop_q != '0);
    accept         = imem_rsp_valid & (drop_q == '0) & (live_q != '0) & ~redirect_valid;
    target_pc      = redirect_pc & ~XLEN'(3);
    drop_sum       = {1'b0, drop_q} + {1'b0, live_q} + (CW + 1)'(fire) - (CW + 1)'(imem_rsp_valid & rsp_owed);
  end

  // next state: a redirect turns every outstanding request into one to discard and empties the buffer
  always_comb begin
    fetch_pc_d = redirect_valid ? target_pc : fire ? fetch_pc_q + XLEN'(4) : fetch_pc_q;
    rsp_pc_d   = redirect_valid ? target_pc : accept ? rsp_pc_q + XLEN'(4) : rsp_pc_q;
    live_d     = redirect_valid ? '0 : live_q + CW'(fire) - CW'(accept);
    drop_d     = redirect_valid ? drop_sum[CW-1:0] : drop_q - CW'(discard);
    count_d    = redirect_valid ? '0 : count_q + CW'(accept) - CW'(pop);
    head_d     = redirect_valid ? '0 : head_q + PW'(pop);
    tail_d     = redirect_valid ? '0 : tail_q + PW'(accept);
  end

  // control state register with asynchronous reset abandoning all in-flight requests
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_q <= START_PC;
      rsp_pc_q   <= START_PC;
      live_q     <= '0;
      drop_q     <= '0;
      count_q    <= '0;
      head_q     <= '0;
      tail_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      live_q     <= live_d;
      drop_q     <= drop_d;
      count_q    <= count_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
    end
  end

  // buffer storage needs no reset; validity comes from count
  always_ff @(posedge clk) begin
    if (accept) begin
      data_q[tail_q] <= imem_rsp_data;
      pc_q[tail_q]   <= rsp_pc_q;
    end
  end
endmodule
